// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath defaults and architectural register names.
package cpu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_rd_mux.sv
// One register-file read port: zero register, write bypass and busy masking.
module regfile_rd_mux
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic [DATA_W-1:0] word,
    input  logic              busy_bit,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    logic is_zero;
    logic hit0;
    logic hit1;

    assign is_zero = ZERO_REG && (addr == ADDR_W'(REG_ZERO));
    assign hit0    = wr0_en && (wr0_addr == addr);
    assign hit1    = wr1_en && (wr1_addr == addr);

    always_comb begin
        data = word;
        if (rst || is_zero) begin
            data = '0;
        end else if (hit1) begin
            data = wr1_data;
        end else if (hit0) begin
            data = wr0_data;
        end
    end

    // A same-cycle write is bypassed, so it no longer blocks the reader.
    assign busy = busy_bit & ~hit0 & ~hit1 & ~is_zero;

endmodule

// File: rtl/regfile_bypass_sb.sv
// GPR file with NRD bypassed read ports, two write ports and a busy scoreboard.
module regfile_bypass_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 3,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wr0_en,
    input  logic [ADDR_W-1:0]     wr0_addr,
    input  logic [DATA_W-1:0]     wr0_data,
    input  logic                  wr1_en,
    input  logic [ADDR_W-1:0]     wr1_addr,
    input  logic [DATA_W-1:0]     wr1_data,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  flush,
    output logic [2**ADDR_W-1:0]  busy_vec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DEPTH-1:0]  wr0_hit;
    logic [DEPTH-1:0]  wr1_hit;
    logic [DEPTH-1:0]  iss_hit;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            wr0_hit[k] = wr0_en && (wr0_addr == ADDR_W'(k));
            wr1_hit[k] = wr1_en && (wr1_addr == ADDR_W'(k));
            iss_hit[k] = iss_en && (iss_addr == ADDR_W'(k));
        end
        if (ZERO_REG) begin
            wr0_hit[REG_ZERO] = 1'b0;
            wr1_hit[REG_ZERO] = 1'b0;
            iss_hit[REG_ZERO] = 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            regs_d[k] = regs_q[k];
            busy_d[k] = busy_q[k];
            if (wr1_hit[k]) begin
                regs_d[k] = wr1_data;
            end else if (wr0_hit[k]) begin
                regs_d[k] = wr0_data;
            end
            // A new issue owns the register even if an older result lands now.
            if (flush) begin
                busy_d[k] = 1'b0;
            end else if (iss_hit[k]) begin
                busy_d[k] = 1'b1;
            end else if (wr0_hit[k] || wr1_hit[k]) begin
                busy_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= regs_d[k];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[i*ADDR_W +: ADDR_W];

        regfile_rd_mux #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .rst      (rst),
            .addr     (a),
            .wr0_en   (wr0_en),
            .wr0_addr (wr0_addr),
            .wr0_data (wr0_data),
            .wr1_en   (wr1_en),
            .wr1_addr (wr1_addr),
            .wr1_data (wr1_data),
            .word     (regs_q[a]),
            .busy_bit (busy_q[a]),
            .data     (rd_data[i*DATA_W +: DATA_W]),
            .busy     (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed and random checks of regfile_bypass_sb against a small reference model.
module tb_regfile_bypass_sb;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 3;
    localparam int DEP = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wr0_en = 1'b0;
    logic [AW-1:0]     wr0_addr = '0;
    logic [DW-1:0]     wr0_data = '0;
    logic              wr1_en = 1'b0;
    logic [AW-1:0]     wr1_addr = '0;
    logic [DW-1:0]     wr1_data = '0;
    logic              iss_en = 1'b0;
    logic [AW-1:0]     iss_addr = '0;
    logic              flush = 1'b0;
    logic [DEP-1:0]    busy_vec;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0]  m_reg [DEP];
    logic [DEP-1:0] m_busy;

    always #5 clk = ~clk;

    regfile_bypass_sb #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NRD      (NRD),
        .ZERO_REG (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    // Reference model, written from the behavioural description.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEP; k++) m_reg[k] <= '0;
            m_busy <= '0;
        end else begin
            if (wr0_en && wr0_addr != 0) m_reg[wr0_addr] <= wr0_data;
            if (wr1_en && wr1_addr != 0) m_reg[wr1_addr] <= wr1_data;
            for (int k = 0; k < DEP; k++) begin
                if (flush)
                    m_busy[k] <= 1'b0;
                else if (iss_en && iss_addr == AW'(k) && k != 0)
                    m_busy[k] <= 1'b1;
                else if ((wr0_en && wr0_addr == AW'(k)) ||
                         (wr1_en && wr1_addr == AW'(k)))
                    m_busy[k] <= 1'b0;
            end
        end
    end

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (rst || a == 0) return '0;
        if (wr1_en && wr1_addr == a) return wr1_data;
        if (wr0_en && wr0_addr == a) return wr0_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (wr0_en && wr0_addr == a) return 1'b0;
        if (wr1_en && wr1_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [DW-1:0] port(input int i);
        return rd_data[i*DW +: DW];
    endfunction

    task automatic idle();
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2);
        rd_addr = {a2, a1, a0};
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        wr0_en = 1'b1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 6;
        @(negedge clk);
        idle();
        set_rd(5, 0, 0);
        #1;
        n_checks++;
        if (port(0) !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL reset_pre_r5: got %h want %h", port(0), 32'hDEADBEEF);
        end
        n_checks++;
        if (busy_vec !== 32'h0000_0040) begin
            n_fail++;
            $display("FAIL reset_pre_busy: got %h want %h", busy_vec, 32'h40);
        end
        rst = 1'b1;
        wr0_en = 1'b1; wr0_addr = 5; wr0_data = 32'h12345678;
        #1;
        n_checks++;
        if (port(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_during_r5: got %h want 0", port(0));
        end
        n_checks++;
        if (busy_vec !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_during_busy: got %h want 0", busy_vec);
        end
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        n_checks++;
        if (port(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_after_r5: got %h want 0", port(0));
        end
        n_checks++;
        if (busy_vec !== 32'h0 || rd_busy !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_after_busy: got %h/%b want 0/000", busy_vec, rd_busy);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        idle();
        wr0_en = 1'b1; wr0_addr = 0; wr0_data = 32'h1234;
        iss_en = 1'b1; iss_addr = 0;
        set_rd(0, 0, 0);
        #1;
        n_checks++;
        if (port(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_same_cycle: got %h want 0", port(0));
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (port(1) !== 32'h0 || rd_busy !== 3'b000 || busy_vec[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_next_cycle: data %h busy %b vec0 %b want 0/000/0",
                     port(1), rd_busy, busy_vec[0]);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        wr0_en = 1'b1; wr0_addr = 7; wr0_data = 32'hA5A5A5A5;
        set_rd(8, 7, 0);
        #1;
        n_checks++;
        if (port(1) !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_same: got %h want %h", port(1), 32'hA5A5A5A5);
        end
        n_checks++;
        if (port(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_other_port: got %h want 0", port(0));
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (port(1) !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL bypass_array: got %h want %h", port(1), 32'hA5A5A5A5);
        end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        idle();
        wr0_en = 1'b1; wr0_addr = 3; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 3; wr1_data = 32'h22;
        set_rd(0, 0, 3);
        #1;
        n_checks++;
        if (port(2) !== 32'h22) begin
            n_fail++;
            $display("FAIL dual_same: got %h want 22", port(2));
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (port(2) !== 32'h22) begin
            n_fail++;
            $display("FAIL dual_next: got %h want 22", port(2));
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        iss_en = 1'b1; iss_addr = 9;
        set_rd(9, 0, 0);
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (rd_busy[0] !== 1'b1 || busy_vec !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL sb_issued: busy %b vec %h want 1/%h", rd_busy[0], busy_vec,
                     32'h200);
        end
        wr0_en = 1'b1; wr0_addr = 9; wr0_data = 32'hCAFE0009;
        #1;
        n_checks++;
        if (rd_busy[0] !== 1'b0 || port(0) !== 32'hCAFE0009) begin
            n_fail++;
            $display("FAIL sb_wb_cycle: busy %b data %h want 0/%h", rd_busy[0], port(0),
                     32'hCAFE0009);
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (rd_busy[0] !== 1'b0 || busy_vec !== 32'h0) begin
            n_fail++;
            $display("FAIL sb_after_wb: busy %b vec %h want 0/0", rd_busy[0], busy_vec);
        end
        iss_en = 1'b1; iss_addr = 9;
        wr0_en = 1'b1; wr0_addr = 9; wr0_data = 32'h77;
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (rd_busy[0] !== 1'b1 || port(0) !== 32'h77) begin
            n_fail++;
            $display("FAIL sb_iss_beats_wr: busy %b data %h want 1/77", rd_busy[0], port(0));
        end
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            idle();
            iss_en = 1'b1; iss_addr = AW'(r);
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (busy_vec !== 32'h0000_020E) begin
            n_fail++;
            $display("FAIL flush_pre: got %h want %h", busy_vec, 32'h20E);
        end
        flush = 1'b1;
        iss_en = 1'b1; iss_addr = 4;
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (busy_vec !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_post: got %h want 0", busy_vec);
        end
    endtask

    task automatic test_random(input int cycles);
        int shown = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            wr0_en   = ($urandom_range(0, 2) != 0);
            wr0_addr = AW'($urandom_range(0, 7));
            wr0_data = $urandom;
            wr1_en   = ($urandom_range(0, 3) == 0);
            wr1_addr = AW'($urandom_range(0, 7));
            wr1_data = $urandom;
            iss_en   = ($urandom_range(0, 1) == 1);
            iss_addr = AW'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NRD; i++)
                rd_addr[i*AW +: AW] = AW'($urandom_range(0, 9));
            #1;
            for (int i = 0; i < NRD; i++) begin
                logic [AW-1:0] a;
                a = rd_addr[i*AW +: AW];
                n_checks++;
                if (port(i) !== exp_data(a) || rd_busy[i] !== exp_busy(a)) begin
                    n_fail++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL rand_port%0d r%0d: data %h busy %b want %h/%b",
                                 i, a, port(i), rd_busy[i], exp_data(a), exp_busy(a));
                    end
                end
            end
            n_checks++;
            if (busy_vec !== m_busy) begin
                n_fail++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand_busy_vec: got %h want %h", busy_vec, m_busy);
                end
            end
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_flush();
        test_random(10000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
